piso_serializer: RTL
====================

Name: piso_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the 4-bit serial-in/parallel-out shift register and drives its serial input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per Clk rising edge.
- Marks data-carrying cycles with Frame and last-bit cycles with Done.
- A one-entry holding register allows back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
IDLE_LEVEL, 0, value driven on Out when no data is being sent

Ports:
Clk  input  1  system clock; all state changes on rising edge
Rst_n  input  1  asynchronous active-low reset
Data  input  WIDTH  parallel word; sampled only on accept
Load_valid  input  1  Data is valid
Load_ready  output  1  block can accept; equals !hold_full (driven from a register, no combinational path from inputs)
Out  output  1  registered serial bit
Frame  output  1  registered; high while Out carries a data bit
Done  output  1  registered; high in the cycle Out carries the last bit of a word

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, bit_cnt=0, hold_full=0, shift register cleared, Out=IDLE_LEVEL, Frame=0, Done=0, Load_ready=1.
- Accept: Load_valid && Load_ready at a rising edge. Load_valid while Load_ready=0 is ignored; the source holds Data until accepted.
- FSM states are IDLE and SHIFT.
- IDLE + accept: Data goes straight into the shift register and the state moves to SHIFT. The first bit appears on Out the cycle after the accept edge (latency 1), with Frame=1.
- SHIFT: each edge presents the next bit on Out and increments bit_cnt over 0..WIDTH-1. Done=1 on the cycle bit_cnt=WIDTH-1 is on Out.
- SHIFT + accept with hold empty: Data goes to the holding register and hold_full=1, so Load_ready=0 from the next cycle.
- Last-bit edge, hold full: the hold word moves to the shift register, hold_full=0, bit_cnt=0. The next word's first bit follows with no gap; Frame stays 1.
- Last-bit edge, hold empty, accept in the same cycle: Data goes directly to the shift register. Contiguous output; no use of hold.
- Last-bit edge, hold empty, no accept: state returns to IDLE. Out=IDLE_LEVEL, Frame=0, Done=0.
- Only one word can enter the hold while it drains. Load_ready is still 0 in the drain cycle, so hold can never be loaded and unloaded in the same edge.
- bit_cnt width is clog2(WIDTH). It never exceeds WIDTH-1 and wraps to 0 on reload.
- Bit select:
  - MSB_FIRST=1: shift left, Out takes sreg[WIDTH-1].
  - MSB_FIRST=0: shift right, Out takes sreg[0].
- Reset mid-word: the current word and any held word are discarded; no partial Done is issued.
- Throughput: one word per WIDTH cycles sustained; Frame is continuous while words are available.

Decomposition:
- Shared package/header holds the state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1, plus the default WIDTH.
- One natural sub-module: piso_bit_counter, a modulo-WIDTH counter with clear/enable and a terminal-count output (bit_cnt==WIDTH-1) driving Done and the reload decision.
- The holding register and FSM stay in the top module.

Test Plan:
1. Reset: hold Rst_n=0 for 3 cycles with Load_valid=1 -> Out=0, Frame=0, Done=0, Load_ready=1 throughout; no accept occurs.
2. Single word, WIDTH=4, MSB_FIRST=1: accept Data=4'b1011 in IDLE -> Out=1,0,1,1 on the next 4 cycles, Frame=1 for exactly those 4 cycles, Done=1 only on the 4th, then Out=0 and Frame=0.
3. Back-to-back: Load_valid held, Data=4'hA then 4'h5 -> Out=1,0,1,0,0,1,0,1 over 8 contiguous cycles, Frame never drops, Done on cycles 4 and 8, Load_ready=0 while hold_full=1.
4. LSB first (MSB_FIRST=0): accept Data=4'b0001 -> Out=1,0,0,0, Done on the 4th bit.
5. Reset mid-word: after 2 bits of 4'hF with 4'h3 held, pulse Rst_n low between edges -> outputs return to reset values immediately, with no clock edge needed. After release, Out stays IDLE_LEVEL until a new accept; 4'h3 is never sent.
6. Backpressure: present a third word 4'hC while Load_ready=0 -> not accepted until Load_ready rises. It is then sent intact with no bit lost or duplicated, and the downstream 4-bit shift register captures 1100 after 4 shifts.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Holds the default word width and the FSM state encoding used by the top.
package piso_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load/serial bundle for piso_serializer.
//   data       : parallel word, sampled only on accept
//   load_valid : data is valid
//   load_ready : serializer can take a word (registered)
//   out        : registered serial bit
//   frame      : out carries a data bit
//   done       : out carries the last bit of a word
// master = word source / serial sink side, slave = serializer side.
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             frame;
  logic             done;

  modport master (
    output data,
    output load_valid,
    input  load_ready,
    input  out,
    input  frame,
    input  done
  );

  modport slave (
    input  data,
    input  load_valid,
    output load_ready,
    output out,
    output frame,
    output done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter for the serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 (priority over en)
//   en         : advance by one, wrapping after WIDTH-1
//   cnt        : current bit index
//   tc         : cnt == WIDTH-1 (last bit of the word)
//   pre_tc     : cnt == WIDTH-2 (next advance reaches the last bit)
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             pre_tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc     = (cnt_q == CNT_W'(WIDTH - 1));
  assign pre_tc = (cnt_q == CNT_W'(WIDTH - 2));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of piso_serializer_if (data/load handshake in,
//                out/frame/done serial stream and load_ready out)
// A word accepted in IDLE shows its first bit on out one cycle later. While
// shifting, one further word may be parked in the hold so consecutive words
// leave with no idle gap. All outputs come straight from flops.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  piso_serializer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic             out_q, out_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;

  logic             accept;
  logic             lead_bit;
  logic             cnt_clr, cnt_en, cnt_tc, cnt_pre_tc;
  logic [CNT_W-1:0] bit_cnt;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (bit_cnt),
    .tc     (cnt_tc),
    .pre_tc (cnt_pre_tc)
  );

  // bit_cnt is only observed through tc/pre_tc.
  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    accept      = bus.load_valid && ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d  = bus.data;
          cnt_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!cnt_tc) begin
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
          cnt_en = 1'b1;
          if (accept) begin
            hold_d      = bus.data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // ready_q is low here, so no accept can collide with the drain.
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_clr     = 1'b1;
        end else if (accept) begin
          sreg_d  = bus.data;
          cnt_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next state so they can be registered.
    lead_bit = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
    frame_d  = (state_d == ST_SHIFT);
    out_d    = frame_d ? lead_bit : IDLE_LEVEL;
    // A reload restarts at bit 0, so only an advance can land on the last bit.
    done_d   = frame_d && cnt_en && cnt_pre_tc;
    ready_d  = !hold_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      out_q       <= IDLE_LEVEL;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      out_q       <= out_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.out        = out_q;
  assign bus.frame      = frame_q;
  assign bus.done       = done_q;

endmodule
